readout_capture: RTL
====================

# readout_capture

Capture side of the digital readout path. Samples the selected output word and its strobe clock from the readout selector, using the fast system clock. Unpacks ADC-TEG words into their two sample fields and buffers captured words in a first-word-fall-through FIFO for the readout/host interface. Runs in the system clock domain; the incoming strobe is treated as asynchronous and slow.

## Interface
Parameters:
- BW, 10, ADC sample width; the captured word is BW+11 bits.
- DEPTH, 8, FIFO depth in entries; must be a power of two, 2 or more.

Ports:
- CLK  input  1  system clock; all logic is on the rising edge.
- RST_N  input  1  reset, synchronous and active-low.
- IN_DATA  input  BW+11  selected word, signed.
- IN_CLK  input  1  selected strobe; a word is valid after each rising edge.
- ENABLE_DFE  input  1  same mode enable that drives the selector.
- ENABLE_ADC_TEG  input  1  same mode enable that drives the selector.
- RD_EN  input  1  pop request.
- CLR_FLAGS  input  1  clears the sticky flags.
- RD_DATA  output  BW+11  FIFO head word.
- RD_TAG  output  1  head entry was captured in ADC-TEG mode.
- RD_TEG_1  output  BW  head bits [2BW-1:BW].
- RD_TEG_2  output  BW  head bits [BW-1:0].
- EMPTY  output  1  FIFO empty.
- FULL  output  1  FIFO full.
- COUNT  output  clog2(DEPTH)+1  number of stored entries.
- OVERFLOW  output  1  sticky flag: a word was dropped because the FIFO was full.
- UNDERFLOW  output  1  sticky flag: RD_EN was asserted while the FIFO was empty.
- FORMAT_ERR  output  1  sticky flag: an ADC-TEG word arrived with bit [2BW] or above nonzero.

## Operation
Mode decode:
- The mode is registered each cycle: DFE (01), TEG (10), or IDLE (00 or 11).
- Captures happen only in DFE or TEG mode. In IDLE, strobe edges are discarded.

Strobe synchronizer:
- IN_CLK passes through two flops (S1, S2). A third flop S3 holds the previous value.
- A capture event is S2=1 and S3=0.
- On a capture event, IN_DATA is sampled in that same cycle. The system guarantees IN_DATA is stable from the IN_CLK rising edge for at least 4 CLK cycles.

Write, on a capture event in a non-IDLE mode:
- FIFO not full, or a pop happens in the same cycle: write {tag = (mode==TEG), IN_DATA} at the write pointer.
- FIFO full with no pop: drop the word and set OVERFLOW.
- TEG mode with IN_DATA[BW+10:2BW] ≠ 0: set FORMAT_ERR. The word is still stored.

Read:
- RD_DATA, RD_TAG and RD_TEG_1/2 always show the head entry (combinational from storage).
- When EMPTY=1 these outputs are 0.
- RD_EN with EMPTY=0 pops at the clock edge.
- RD_EN with EMPTY=1 is ignored and sets UNDERFLOW.

Mode change:
- Any change of the registered mode flushes the FIFO on the next edge: pointers and COUNT go to 0.
- A capture event in that flush cycle is discarded.
- Sticky flags are not affected by a flush.

Pointers and flags:
- Pointers are clog2(DEPTH) bits wide and wrap modulo DEPTH.
- COUNT increments on write, decrements on pop, and is unchanged when both happen.
- FULL = (COUNT==DEPTH). EMPTY = (COUNT==0).
- CLR_FLAGS clears all sticky flags. If a set condition occurs in the same cycle, set wins.

Reset:
- Synchronizer flops, mode register, pointers, COUNT and all flags go to 0.
- RD_* = 0, EMPTY = 1, FULL = 0.
- The storage array is not reset.
- Reset asserted mid-operation discards all stored entries at that edge.

## Timing
- Capture latency: IN_CLK is first sampled high at edge k (S1=1). S2=1 at k+1. The entry is written at edge k+2.
  - EMPTY falls and the new RD_DATA is visible after edge k+2.
- Minimum IN_CLK high and low time is 3 CLK cycles each; shorter pulses may be missed.
- Pop: RD_EN sampled at edge n. COUNT and the head advance after edge n. Back-to-back pops are allowed every cycle.
- Flags update at the edge of the causing event.
- A mode change registered at edge m causes a flush at edge m+1.

## Test plan
- Reset, DFE mode, three IN_CLK pulses with IN_DATA = 21'h0ABCDE, 21'h100001, 21'h1FFFFF -> COUNT=3; popped words in order with RD_TAG=0; EMPTY after the third pop.
- TEG mode, IN_DATA={0, 10'h2A5, 10'h15A} -> RD_TAG=1, RD_TEG_1=10'h2A5, RD_TEG_2=10'h15A, FORMAT_ERR=0. Then IN_DATA bit 20 = 1 -> FORMAT_ERR=1 and the word is stored.
- DEPTH+1 strobes with no reads -> FULL=1, COUNT=8, OVERFLOW=1, the first 8 words are intact. Then a strobe in the same cycle as a pop is accepted and COUNT stays 8.
- RD_EN while empty -> UNDERFLOW=1, COUNT stays 0. CLR_FLAGS clears it. CLR_FLAGS together with a new underflow leaves UNDERFLOW=1.
- Both enables high, or both low, with strobes toggling -> no writes, EMPTY stays 1. Switching DFE→TEG with 2 entries stored -> flush, COUNT=0 one cycle after the mode register update.
- IN_CLK pulse exactly 3 CLK high -> captured once. Reset asserted with 4 entries stored -> EMPTY=1, COUNT=0, flags 0 after that edge.

Source files
------------

// File: rtl/readout_capture.sv
// Capture side of the readout path: synchronizes the slow selector strobe, captures the
// selected word and buffers it, with its mode tag, in a first-word-fall-through FIFO.
module readout_capture #(
  parameter int unsigned BW    = 10,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic [BW+10:0]             IN_DATA,
  input  logic                       IN_CLK,
  input  logic                       ENABLE_DFE,
  input  logic                       ENABLE_ADC_TEG,
  input  logic                       RD_EN,
  input  logic                       CLR_FLAGS,
  output logic [BW+10:0]             RD_DATA,
  output logic                       RD_TAG,
  output logic [BW-1:0]              RD_TEG_1,
  output logic [BW-1:0]              RD_TEG_2,
  output logic                       EMPTY,
  output logic                       FULL,
  output logic [$clog2(DEPTH):0]     COUNT,
  output logic                       OVERFLOW,
  output logic                       UNDERFLOW,
  output logic                       FORMAT_ERR
);

  localparam int unsigned DW   = BW + 11;
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {
    ModeIdle = 2'b00,
    ModeDfe  = 2'b01,
    ModeTeg  = 2'b10
  } mode_e;

  logic            s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  mode_e           mode_q, mode_d, mode_last_q, mode_last_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            ovf_q, ovf_d, unf_q, unf_d, fmt_q, fmt_d;
  logic [DW:0]     mem_q [DEPTH];
  logic [DW:0]     head;
  logic            flush, cap, empty, full, pop, wr;

  always_comb begin
    s1_d        = IN_CLK;
    s2_d        = s1_q;
    s3_d        = s2_q;
    mode_last_d = mode_q;
    case ({ENABLE_ADC_TEG, ENABLE_DFE})
      2'b01:   mode_d = ModeDfe;
      2'b10:   mode_d = ModeTeg;
      default: mode_d = ModeIdle;
    endcase

    // A registered mode change flushes the FIFO on the following edge; captures then are lost.
    flush = (mode_q != mode_last_q);
    cap   = s2_q & ~s3_q & (mode_q != ModeIdle) & ~flush;
    empty = (count_q == '0);
    full  = (count_q == CntW'(DEPTH));
    pop   = RD_EN & ~empty;
    wr    = cap & (~full | pop);

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr)  wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop) rd_ptr_d = rd_ptr_q + PtrW'(1);
      if (wr && !pop)      count_d = count_q + CntW'(1);
      else if (pop && !wr) count_d = count_q - CntW'(1);
    end

    // Clear first, so a set condition in the same cycle wins.
    ovf_d = (ovf_q & ~CLR_FLAGS) | (cap & full & ~pop);
    unf_d = (unf_q & ~CLR_FLAGS) | (RD_EN & empty);
    fmt_d = (fmt_q & ~CLR_FLAGS) | (cap & (mode_q == ModeTeg) & ((IN_DATA >> (2 * BW)) != '0));
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      s3_q        <= 1'b0;
      mode_q      <= ModeIdle;
      mode_last_q <= ModeIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      fmt_q       <= 1'b0;
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      s3_q        <= s3_d;
      mode_q      <= mode_d;
      mode_last_q <= mode_last_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      fmt_q       <= fmt_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr) mem_q[wr_ptr_q] <= {mode_q == ModeTeg, IN_DATA};
  end

  always_comb begin
    head = empty ? '0 : mem_q[rd_ptr_q];
  end

  assign RD_DATA    = head[DW-1:0];
  assign RD_TAG     = head[DW];
  assign RD_TEG_1   = head[2*BW-1:BW];
  assign RD_TEG_2   = head[BW-1:0];
  assign EMPTY      = empty;
  assign FULL       = full;
  assign COUNT      = count_q;
  assign OVERFLOW   = ovf_q;
  assign UNDERFLOW  = unf_q;
  assign FORMAT_ERR = fmt_q;

endmodule
